// File: rtl/tx_fifo_pkt_sched.sv
// tx_fifo_pkt_sched: TX FIFO read scheduler that cuts the byte stream into fixed-length packets for the UDP stack.
// Optional feature: define TX_SCHED_TIMEOUT_FLUSH_EN to flush a short packet after TIMEOUT_CYCLES of stalled residual data.
module tx_fifo_pkt_sched #(
    parameter int PKT_LEN        = 1024,
    parameter int WR_BYTES       = 16,
    parameter int OCC_W          = 13,
    parameter int GAP_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_wr_en,
    input  logic        fifo_wr_full,
    input  logic        fifo_rd_empty,
    output logic        fifo_rd_en,
    input  logic [7:0]  fifo_rd_data,
    output logic        tx_req,
    output logic [15:0] tx_len,
    input  logic        tx_ack,
    input  logic        tx_data_req,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    output logic        tx_busy,
    output logic        ovf_err
);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [OCC_W-1:0] OCC_PKT  = OCC_W'(PKT_LEN);
    localparam logic [OCC_W-1:0] OCC_INC  = OCC_W'(WR_BYTES);
    localparam logic [15:0]      LEN_PKT  = 16'(PKT_LEN);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, SEND, GAP} state_t;

    state_t state, state_nx;
    logic [OCC_W-1:0] occ;
    logic [15:0] sent, len_q;
    logic [GAP_W-1:0] gap_cnt;
    logic rd_q, wr_ok, flush;

    assign wr_ok = fifo_wr_en & ~fifo_wr_full;

`ifdef TX_SCHED_TIMEOUT_FLUSH_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall;
    logic residual;

    assign residual = (state == IDLE) && (occ != '0) && (occ < OCC_PKT);
    assign flush    = residual && (stall == STALL_W'(TIMEOUT_CYCLES));

    // stall timer: runs only while a partial packet sits idle, restarts on every accepted write
    always_ff @(posedge clk)
        stall <= (rst || wr_ok || !residual) ? '0 : stall + STALL_W'(1);
`else
    // residual bytes simply wait for more data; the comparison is constant false
    assign flush = (TIMEOUT_CYCLES < 0);
`endif

    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (occ >= OCC_PKT || flush) state_nx = REQ;
            REQ:  if (tx_ack) state_nx = SEND;
            SEND: if (sent == len_q && rd_q) state_nx = GAP;
            GAP:  if (gap_cnt == GAP_LAST) state_nx = IDLE;
        endcase
    end

    // outputs: read is issued combinationally, data is qualified one cycle later by rd_q
    always_comb begin
        fifo_rd_en    = (state == SEND) && tx_data_req && (sent < len_q) && !fifo_rd_empty;
        tx_req        = (state == REQ);
        tx_busy       = (state != IDLE);
        tx_len        = len_q;
        tx_data_valid = rd_q;
        tx_data       = rd_q ? fifo_rd_data : '0;
    end

    // datapath: occupancy, byte count, latched length, read-latency tap, gap timer, overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            occ     <= '0;
            sent    <= '0;
            len_q   <= '0;
            rd_q    <= 1'b0;
            gap_cnt <= '0;
            ovf_err <= 1'b0;
        end else begin
            occ     <= occ + (wr_ok ? OCC_INC : '0) - OCC_W'(fifo_rd_en);
            sent    <= (state == IDLE) ? '0 : sent + 16'(fifo_rd_en);
            rd_q    <= fifo_rd_en;
            gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
            ovf_err <= ovf_err | (fifo_wr_en & fifo_wr_full);
            if (state == IDLE && state_nx == REQ)
                len_q <= (occ >= OCC_PKT) ? LEN_PKT : 16'(occ);
        end
    end
endmodule
